// File: rtl/alu_seq_pkg.sv
// Shared definitions for the accumulator command sequencer: command layout,
// accumulator mode codes and the sequencer FSM encoding.
package alu_seq_pkg;

  // Command word layout {m, a, b, cin}
  localparam int unsigned OPND_W  = 4;
  localparam int unsigned CMD_W   = 13;
  localparam int unsigned M_LSB   = 9;
  localparam int unsigned A_LSB   = 5;
  localparam int unsigned B_LSB   = 1;
  localparam int unsigned CIN_LSB = 0;

  typedef struct packed {
    logic [OPND_W-1:0] m;
    logic [OPND_W-1:0] a;
    logic [OPND_W-1:0] b;
    logic              cin;
  } alu_cmd_t;

  // Accumulator mode codes, passed through untouched by the sequencer
  localparam logic [3:0] MODE_ADD  = 4'h0;
  localparam logic [3:0] MODE_SUB  = 4'h1;
  localparam logic [3:0] MODE_CMP  = 4'h2;
  localparam logic [3:0] MODE_AND  = 4'h3;
  localparam logic [3:0] MODE_OR   = 4'h4;
  localparam logic [3:0] MODE_NOT  = 4'h5;
  localparam logic [3:0] MODE_INC  = 4'h6;
  localparam logic [3:0] MODE_DEC  = 4'h7;
  localparam logic [3:0] MODE_SHL0 = 4'h8;
  localparam logic [3:0] MODE_SHL1 = 4'h9;
  localparam logic [3:0] MODE_SHR0 = 4'hA;
  localparam logic [3:0] MODE_SHR1 = 4'hB;
  localparam logic [3:0] MODE_ASL  = 4'hC;
  localparam logic [3:0] MODE_ASR  = 4'hD;
  localparam logic [3:0] MODE_ROL  = 4'hE;
  localparam logic [3:0] MODE_ROR  = 4'hF;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Circular command FIFO with registered status flags. A push into a full
// FIFO is dropped and flagged, even when a pop happens in the same cycle.
module alu_cmd_fifo
  import alu_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = CMD_W
) (
  input  logic                     Clk,
  input  logic                     nReset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     push_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_d;
  logic             do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr_q];

  // Next occupancy; simultaneous push and pop cancel out
  always_comb begin
    count_d = count;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count + CW'(1);
      2'b01:   count_d = count - CW'(1);
      default: count_d = count;
    endcase
  end

  // Pointers, occupancy and status flags; flush wins over push/pop
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      push_err <= 1'b0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      push_err <= 1'b0;
    end else begin
      push_err <= push & full;
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count <= count_d;
      full  <= (count_d == CW'(DEPTH));
      empty <= (count_d == '0);
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge Clk) begin
    if (do_push && !flush) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the accumulator ALU: queues commands, issues them one at a
// time, holds each for the result latency and captures r/of with a sticky
// overflow flag.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned RESULT_LAT = 1
) (
  input  logic                   Clk,
  input  logic                   nReset,
  input  logic                   wr_en,
  input  logic [CMD_W-1:0]       wr_cmd,
  input  logic                   start,
  input  logic                   abort,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   push_err,
  output logic [3:0]             a,
  output logic [3:0]             b,
  output logic [3:0]             m,
  output logic                   cin,
  output logic                   issue,
  input  logic [3:0]             r,
  input  logic                   of,
  output logic [3:0]             res_r,
  output logic                   res_valid,
  output logic                   of_seen,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned LW = $clog2(RESULT_LAT + 1);

  seq_state_e       state_q;
  logic [LW-1:0]    wait_cnt_q;
  logic [CMD_W-1:0] fifo_head;
  alu_cmd_t         head_cmd;
  logic             fifo_pop;

  assign head_cmd = alu_cmd_t'(fifo_head);
  assign fifo_pop = (state_q == StIssue) && !abort;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .Clk       (Clk),
    .nReset    (nReset),
    .flush     (abort),
    .push      (wr_en),
    .push_data (wr_cmd),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .push_err  (push_err)
  );

  // Sequencer FSM with registered operand, capture and status outputs
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      a          <= '0;
      b          <= '0;
      m          <= '0;
      cin        <= 1'b0;
      issue      <= 1'b0;
      res_r      <= '0;
      res_valid  <= 1'b0;
      of_seen    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      issue     <= 1'b0;
      res_valid <= 1'b0;
      done      <= 1'b0;
      if (abort) begin
        // Operands and of_seen deliberately keep their values
        state_q <= StIdle;
        busy    <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start && !empty) begin
              of_seen <= 1'b0;
              busy    <= 1'b1;
              state_q <= StIssue;
            end
          end
          StIssue: begin
            m          <= head_cmd.m;
            a          <= head_cmd.a;
            b          <= head_cmd.b;
            cin        <= head_cmd.cin;
            issue      <= 1'b1;
            wait_cnt_q <= LW'(RESULT_LAT);
            state_q    <= StWait;
          end
          StWait: begin
            wait_cnt_q <= wait_cnt_q - LW'(1);
            if (wait_cnt_q == LW'(1)) begin
              res_r     <= r;
              res_valid <= 1'b1;
              if (of) of_seen <= 1'b1;
              if (!empty) begin
                state_q <= StIssue;
              end else begin
                done    <= 1'b1;
                busy    <= 1'b0;
                state_q <= StIdle;
              end
            end
          end
          default: begin
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

endmodule
